avalon_bus_arbiter: RTL



---
 rtl/avalon_bus_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter: fixed priority to master 0 with a starvation counter for master 1.
// Define ARB_ROUND_ROBIN_EN to replace the starvation counter with strict alternation under contention.
module avalon_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant
);

  // Handshake: a master holds read/write and its payload stable while its waitrequest is 1;
  // the transfer completes in the cycle where the owner requests and s_waitrequest is 0.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic req0;
  logic req1;
  logic tie_to_m1;
  logic enter_own0;
  logic enter_own1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign enter_own0 = (state_q == IDLE) && (state_d == OWN0);
  assign enter_own1 = (state_q == IDLE) && (state_d == OWN1);

`ifdef ARB_ROUND_ROBIN_EN
  // last_owner = 1 after reset so master 0 takes the first tie.
  logic last_owner_q;

  assign tie_to_m1 = (last_owner_q == 1'b0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= 1'b1;
    end else if (enter_own0) begin
      last_owner_q <= 1'b0;
    end else if (enter_own1) begin
      last_owner_q <= 1'b1;
    end
  end
`else
  localparam logic [7:0] STARVE_LIMIT_W = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q;

  assign tie_to_m1 = (starve_cnt_q >= STARVE_LIMIT_W);

  // Counts master-0 grants taken while master 1 waits; any edge without a master-1 request clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 8'd0;
    end else if (!req1 || enter_own1) begin
      starve_cnt_q <= 8'd0;
    end else if (enter_own0 && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_q <= starve_cnt_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each grant covers one transfer: leave on completion or on withdrawal of the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = tie_to_m1 ? OWN1 : OWN0;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!req0 || !s_waitrequest) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (!req1 || !s_waitrequest) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address      = 32'd0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = 32'd0;
    s_byteenable   = 4'd0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    case (state_q)
      OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
      end
      OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
      end
      default: begin
      end
    endcase
  end

  // Only the granted master samples read data.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule
